// File: rtl/score_keeper_guarded.sv
// Guarded multi-team score keeper: add/subtract 0..3 points with range checks and accept/reject pulses.
// Optional macro SCORE_UNDO_EN adds cmd_undo and a one-deep undo record.
module score_keeper_guarded #(
  parameter int unsigned TEAMS     = 2,
  parameter int unsigned SCORE_W   = 7,
  parameter int unsigned MAX_SCORE = 99,
  parameter int unsigned TEAM_W    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       cmd_valid,
  input  logic [TEAM_W-1:0]          cmd_team,
  input  logic [1:0]                 cmd_points,
  input  logic                       cmd_sub,
`ifdef SCORE_UNDO_EN
  input  logic                       cmd_undo,
`endif
  output logic                       cmd_ready,
  output logic                       busy,
  output logic                       accepted,
  output logic                       rejected,
  output logic [TEAMS*SCORE_W-1:0]   score_flat
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_COMMIT,
    S_WAIT_RELEASE
  } state_t;

  state_t              r_state;
  logic [SCORE_W-1:0]  r_score [TEAMS];
  logic [TEAM_W-1:0]   r_team;
  logic [1:0]          r_points;
  logic                r_sub;
  logic                r_ok;
  logic [SCORE_W-1:0]  r_new;
  logic [TEAM_W-1:0]   r_wteam;

`ifdef SCORE_UNDO_EN
  logic                r_undo;
  logic                r_rec_valid;
  logic [TEAM_W-1:0]   r_rec_team;
  logic [1:0]          r_rec_points;
  logic                r_rec_sub;
`endif

  logic [TEAM_W-1:0]   w_team;
  logic [1:0]          w_points;
  logic                w_sub;
  logic                w_legal;
  logic                w_team_ok;
  logic [SCORE_W-1:0]  w_cur;
  logic [SCORE_W:0]    w_sum;
  logic [SCORE_W-1:0]  w_diff;
  logic                w_ok;
  logic [SCORE_W-1:0]  w_new;

  // Verdict for the latched command; an undo replays the record with the sign inverted.
  always_comb begin
    w_team    = r_team;
    w_points  = r_points;
    w_sub     = r_sub;
    w_legal   = 1'b1;
`ifdef SCORE_UNDO_EN
    if (r_undo) begin
      w_team   = r_rec_team;
      w_points = r_rec_points;
      w_sub    = ~r_rec_sub;
      w_legal  = r_rec_valid;
    end
`endif
    w_cur     = '0;
    w_team_ok = 1'b0;
    for (int unsigned k = 0; k < TEAMS; k++) begin
      if (w_team == TEAM_W'(k)) begin
        w_cur     = r_score[k];
        w_team_ok = 1'b1;
      end
    end
    w_sum  = {1'b0, w_cur} + (SCORE_W+1)'(w_points);
    w_diff = w_cur - SCORE_W'(w_points);
    if (w_sub) begin
      w_ok  = w_legal && w_team_ok && (SCORE_W'(w_points) <= w_cur);
      w_new = w_diff;
    end else begin
      w_ok  = w_legal && w_team_ok && (w_sum <= (SCORE_W+1)'(MAX_SCORE));
      w_new = w_sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_WAIT_RELEASE;
      cmd_ready <= 1'b0;
      busy      <= 1'b1;
      accepted  <= 1'b0;
      rejected  <= 1'b0;
      r_team    <= '0;
      r_points  <= '0;
      r_sub     <= 1'b0;
      r_ok      <= 1'b0;
      r_new     <= '0;
      r_wteam   <= '0;
      for (int unsigned k = 0; k < TEAMS; k++) r_score[k] <= '0;
`ifdef SCORE_UNDO_EN
      r_undo       <= 1'b0;
      r_rec_valid  <= 1'b0;
      r_rec_team   <= '0;
      r_rec_points <= '0;
      r_rec_sub    <= 1'b0;
`endif
    end else begin
      accepted <= 1'b0;
      rejected <= 1'b0;
      if (clr) begin
        // Game clear drops any in-flight command without a pulse.
        for (int unsigned k = 0; k < TEAMS; k++) r_score[k] <= '0;
        r_state   <= S_WAIT_RELEASE;
        cmd_ready <= 1'b0;
        busy      <= 1'b1;
`ifdef SCORE_UNDO_EN
        r_rec_valid <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cmd_valid) begin
              r_team    <= cmd_team;
              r_points  <= cmd_points;
              r_sub     <= cmd_sub;
`ifdef SCORE_UNDO_EN
              r_undo    <= cmd_undo;
`endif
              r_state   <= S_CHECK;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
          S_CHECK: begin
            r_ok    <= w_ok;
            r_new   <= w_new;
            r_wteam <= w_team;
            r_state <= S_COMMIT;
          end
          S_COMMIT: begin
            if (r_ok) begin
              for (int unsigned k = 0; k < TEAMS; k++) begin
                if (r_wteam == TEAM_W'(k)) r_score[k] <= r_new;
              end
              accepted <= 1'b1;
`ifdef SCORE_UNDO_EN
              if (r_undo) begin
                r_rec_valid <= 1'b0;
              end else begin
                r_rec_valid  <= 1'b1;
                r_rec_team   <= r_team;
                r_rec_points <= r_points;
                r_rec_sub    <= r_sub;
              end
`endif
            end else begin
              rejected <= 1'b1;
`ifdef SCORE_UNDO_EN
              r_rec_valid <= 1'b0;
`endif
            end
            r_state <= S_WAIT_RELEASE;
          end
          S_WAIT_RELEASE: begin
            if (!cmd_valid) begin
              r_state   <= S_IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
          default: begin
            r_state   <= S_WAIT_RELEASE;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < TEAMS; g++) begin : g_flat
    assign score_flat[g*SCORE_W +: SCORE_W] = r_score[g];
  end

endmodule

// File: tb/tb_score_keeper_guarded.sv
// Scoreboard bench for score_keeper_guarded: driver queues expected pulses, monitor checks them.
module tb_score_keeper_guarded;

  logic        clk;
  logic        reset;
  logic        clr;
  logic        cmd_valid;
  logic [0:0]  cmd_team;
  logic [1:0]  cmd_points;
  logic        cmd_sub;
`ifdef SCORE_UNDO_EN
  logic        cmd_undo;
`endif
  logic        cmd_ready;
  logic        busy;
  logic        accepted;
  logic        rejected;
  logic [13:0] score_flat;

  typedef struct {
    bit          acc;
    logic [13:0] flat;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   acc_cnt = 0;

  score_keeper_guarded dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .cmd_valid  (cmd_valid),
    .cmd_team   (cmd_team),
    .cmd_points (cmd_points),
    .cmd_sub    (cmd_sub),
`ifdef SCORE_UNDO_EN
    .cmd_undo   (cmd_undo),
`endif
    .cmd_ready  (cmd_ready),
    .busy       (busy),
    .accepted   (accepted),
    .rejected   (rejected),
    .score_flat (score_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [13:0] fl(input int t0, input int t1);
    return {7'(t1), 7'(t0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    if (!reset && (accepted || rejected)) begin
      if (accepted) acc_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: acc=%0b rej=%0b flat=%0h at cyc %0d", accepted, rejected, score_flat, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({accepted, rejected} !== {e.acc, ~e.acc} || score_flat !== e.flat || cyc != e.cyc) begin
          errors++;
          $display("FAIL pulse: acc=%0b rej=%0b flat=%0h cyc=%0d expected acc=%0b flat=%0h cyc=%0d",
                   accepted, rejected, score_flat, cyc, e.acc, e.flat, e.cyc);
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: cmd_ready=%0b expected 1", cmd_ready);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic press(input int team, input int pts, input bit sub, input bit undo,
                       input int hold, input bit exp_acc, input logic [13:0] exp_flat);
    exp_t e;
    wait_ready();
    cmd_valid  = 1'b1;
    cmd_team   = 1'(team);
    cmd_points = 2'(pts);
    cmd_sub    = sub;
`ifdef SCORE_UNDO_EN
    cmd_undo   = undo;
`else
    if (undo) $display("undo skipped");
`endif
    e.acc  = exp_acc;
    e.flat = exp_flat;
    e.cyc  = cyc + 3;
    exp_q.push_back(e);
    repeat (hold) @(negedge clk);
    cmd_valid = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clr = 1'b0; cmd_valid = 1'b1;
    cmd_team = '0; cmd_points = 2'd3; cmd_sub = 1'b0;
`ifdef SCORE_UNDO_EN
    cmd_undo = 1'b0;
`endif
    // Reset with the button held: no command may fire.
    repeat (5) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_pulses", 32'({accepted, rejected}), 0);
    check("rst_flat", 32'(score_flat), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("held_ready", 32'(cmd_ready), 0);
    check("held_busy", 32'(busy), 1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("release_ready", 32'(cmd_ready), 1);
    check("release_busy", 32'(busy), 0);
    check("release_flat", 32'(score_flat), 0);

    for (int i = 0; i < 33; i++) press(0, 3, 1'b0, 1'b0, 1, 1'b1, fl(3*(i+1), 0));
    check("acc_count_33", 32'(acc_cnt), 33);
    press(0, 1, 1'b0, 1'b0, 1, 1'b0, fl(99, 0));
    press(0, 0, 1'b0, 1'b0, 1, 1'b1, fl(99, 0));
    press(1, 2, 1'b0, 1'b0, 1, 1'b1, fl(99, 2));
    press(1, 3, 1'b1, 1'b0, 1, 1'b0, fl(99, 2));
    press(1, 2, 1'b1, 1'b0, 1, 1'b1, fl(99, 0));
    press(1, 0, 1'b1, 1'b0, 1, 1'b1, fl(99, 0));

    // clr in the CHECK cycle of an add-3: no pulse, scores zeroed, re-arm only after release.
    wait_ready();
    cmd_valid = 1'b1; cmd_team = 1'b1; cmd_points = 2'd3; cmd_sub = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_flat", 32'(score_flat), 0);
    repeat (4) @(negedge clk);
    check("clr_held_ready", 32'(cmd_ready), 0);
    check("clr_flat_after", 32'(score_flat), 0);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("clr_release_ready", 32'(cmd_ready), 1);

    acc_cnt = 0;
    press(0, 2, 1'b0, 1'b0, 20, 1'b1, fl(2, 0));
    check("hold_one_pulse", 32'(acc_cnt), 1);
    press(0, 2, 1'b0, 1'b0, 1, 1'b1, fl(4, 0));
    press(1, 3, 1'b0, 1'b0, 1, 1'b1, fl(4, 3));
    press(1, 3, 1'b1, 1'b0, 1, 1'b1, fl(4, 0));

`ifdef SCORE_UNDO_EN
    press(0, 3, 1'b0, 1'b0, 1, 1'b1, fl(7, 0));
    press(0, 3, 1'b0, 1'b0, 1, 1'b1, fl(10, 0));
    press(0, 3, 1'b0, 1'b0, 1, 1'b1, fl(13, 0));
    press(0, 0, 1'b0, 1'b1, 1, 1'b1, fl(10, 0));
    press(0, 0, 1'b0, 1'b1, 1, 1'b0, fl(10, 0));
`endif

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
